bist_sig_analyzer: RTL and testbench



---
 rtl/bist_sig_analyzer.sv | 121 ++++++++++++
 tb/tb_bist_sig_analyzer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bist_sig_analyzer.sv
// BIST response compactor: MISR signature over PATTERNS captures, then golden compare -> done/pass.
// Optional feature macro: SIG_XMASK_EN (masks XMASK bits of resp before compaction).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; capture_en ignored
// S_COMPACT | folding resp into the MISR on each capture_en cycle
// S_COMPARE | one cycle; latches signature==GOLDEN
// S_DONE    | verdict held on done/pass, signature frozen until start
module bist_sig_analyzer #(
  parameter int                WIDTH    = 49,
  parameter int                PATTERNS = 2000,
  parameter int                CNT_W    = 16,
  parameter logic [WIDTH-1:0]  POLY     = WIDTH'(49'h0_0000_0000_0201),
  parameter logic [WIDTH-1:0]  GOLDEN   = '0,
  parameter logic [WIDTH-1:0]  XMASK    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             capture_en,
  input  logic [WIDTH-1:0] resp,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {S_IDLE, S_COMPACT, S_COMPARE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sig;
  logic [CNT_W-1:0] r_count;
  logic             r_match, r_done, r_pass;
  logic             w_clr, w_capture, w_last;
  logic [WIDTH-1:0] w_resp_eff, w_sig_nxt;

`ifdef SIG_XMASK_EN
  assign w_resp_eff = resp & ~XMASK;
`else
  // Keeps XMASK referenced in the unmasked build; folds to a plain wire.
  assign w_resp_eff = resp | (XMASK & {WIDTH{1'b0}});
`endif

  assign w_sig_nxt = {r_sig[WIDTH-2:0], 1'b0}
                   ^ (r_sig[WIDTH-1] ? POLY : {WIDTH{1'b0}})
                   ^ w_resp_eff;

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_capture   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_COMPACT;
          w_clr       = 1'b1;
        end
      end
      S_COMPACT: begin
        // start wins over capture_en; that cycle's response is dropped
        if (start) begin
          w_clr = 1'b1;
        end else if (capture_en) begin
          w_capture = 1'b1;
          if (r_count == LAST_CNT) begin
            w_last      = 1'b1;
            w_state_nxt = S_COMPARE;
          end
        end
      end
      S_COMPARE: begin
        if (start) begin
          w_state_nxt = S_COMPACT;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_COMPACT;
          w_clr       = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sig   <= '0;
      r_count <= '0;
      r_match <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_sig   <= '0;
        r_count <= '0;
      end else if (w_capture) begin
        r_sig <= w_sig_nxt;
        if (!w_last) r_count <= r_count + 1'b1;
      end
      if (w_clr) r_match <= 1'b0;
      else if (r_state == S_COMPARE) r_match <= (r_sig == GOLDEN);
      // Pin stage: verdict reaches bistdone/bistpass one edge after COMPARE
      r_done <= (r_state == S_DONE) && !w_clr;
      r_pass <= (r_state == S_DONE) && !w_clr && r_match;
    end
  end

  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_bist_sig_analyzer.sv
// Directed bench for bist_sig_analyzer: 4-bit MISR, POLY=0011, PATTERNS=2, GOLDEN=1011, XMASK=0001.
module tb_bist_sig_analyzer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       capture_en;
  logic [3:0] resp;
  logic       done;
  logic       pass;
  logic [3:0] signature;

  int n_cmp = 0;
  int n_err = 0;

  bist_sig_analyzer #(
    .WIDTH   (4),
    .PATTERNS(2),
    .CNT_W   (16),
    .POLY    (4'b0011),
    .GOLDEN  (4'b1011),
    .XMASK   (4'b0001)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .capture_en(capture_en),
    .resp      (resp),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       st;
    logic       cap;
    logic [3:0] rsp;
    logic [3:0] e_sig;
    logic       e_done;
    logic       e_pass;
  } vec_t;

  vec_t vq[$];

`ifdef SIG_XMASK_EN
  localparam logic [3:0] XM_S1 = 4'b1000;
  localparam logic [3:0] XM_S2 = 4'b1011;
  localparam logic       XM_P  = 1'b1;
`else
  localparam logic [3:0] XM_S1 = 4'b1001;
  localparam logic [3:0] XM_S2 = 4'b1000;
  localparam logic       XM_P  = 1'b0;
`endif

  function automatic vec_t mk(logic r, logic s, logic c, logic [3:0] rs,
                              logic [3:0] es, logic ed, logic ep);
    vec_t v;
    v.rst_n = r; v.st = s; v.cap = c; v.rsp = rs;
    v.e_sig = es; v.e_done = ed; v.e_pass = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic s, logic c, logic [3:0] rs);
    @(negedge clk);
    rst = r; start = s; capture_en = c; resp = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; capture_en = 1'b0; resp = 4'b0;

    // rst, start, cap, resp -> signature, done, pass after the edge
    vq.push_back(mk(0,0,0,4'b0000, 4'b0000,0,0)); // reset
    vq.push_back(mk(1,0,1,4'b1111, 4'b0000,0,0)); // capture in IDLE ignored
    vq.push_back(mk(1,1,0,4'b0000, 4'b0000,0,0)); // start
    vq.push_back(mk(1,0,1,4'b1000, 4'b1000,0,0));
    vq.push_back(mk(1,0,1,4'b1000, 4'b1011,0,0)); // last capture
    vq.push_back(mk(1,0,0,4'b0000, 4'b1011,0,0)); // COMPARE edge
    vq.push_back(mk(1,0,0,4'b0000, 4'b1011,1,1)); // verdict
    vq.push_back(mk(1,0,1,4'b0101, 4'b1011,1,1)); // capture in DONE ignored
    vq.push_back(mk(1,1,0,4'b0000, 4'b0000,0,0)); // restart from DONE
    vq.push_back(mk(1,0,1,4'b0001, 4'b0001,0,0));
    vq.push_back(mk(1,0,1,4'b0010, 4'b0000,0,0));
    vq.push_back(mk(1,0,0,4'b0000, 4'b0000,0,0));
    vq.push_back(mk(1,0,0,4'b0000, 4'b0000,1,0)); // fail verdict
    vq.push_back(mk(1,1,0,4'b0000, 4'b0000,0,0)); // stall run
    vq.push_back(mk(1,0,1,4'b1000, 4'b1000,0,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,0,0,4'b1111, 4'b1000,0,0));
    vq.push_back(mk(1,0,1,4'b1000, 4'b1011,0,0));
    vq.push_back(mk(1,0,0,4'b0000, 4'b1011,0,0));
    vq.push_back(mk(1,0,0,4'b0000, 4'b1011,1,1));
    vq.push_back(mk(1,1,0,4'b0000, 4'b0000,0,0)); // start+capture in COMPACT
    vq.push_back(mk(1,0,1,4'b0001, 4'b0001,0,0));
    vq.push_back(mk(1,1,1,4'b1111, 4'b0000,0,0)); // restart, resp dropped
    vq.push_back(mk(1,0,1,4'b1000, 4'b1000,0,0)); // count restarted
    vq.push_back(mk(1,0,1,4'b1000, 4'b1011,0,0));
    vq.push_back(mk(1,0,1,4'b1111, 4'b1011,0,0)); // capture in COMPARE ignored
    vq.push_back(mk(1,0,0,4'b0000, 4'b1011,1,1));
    vq.push_back(mk(1,1,0,4'b0000, 4'b0000,0,0)); // mask run
    vq.push_back(mk(1,0,1,4'b1001, XM_S1,0,0));
    vq.push_back(mk(1,0,1,4'b1001, XM_S2,0,0));
    vq.push_back(mk(1,0,0,4'b0000, XM_S2,0,0));
    vq.push_back(mk(1,0,0,4'b0000, XM_S2,1,XM_P));

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].st, vq[i].cap, vq[i].rsp);
      chk($sformatf("vec%0d sig", i),  signature,   vq[i].e_sig);
      chk($sformatf("vec%0d done", i), {3'b0,done}, {3'b0,vq[i].e_done});
      chk($sformatf("vec%0d pass", i), {3'b0,pass}, {3'b0,vq[i].e_pass});
    end

    // Reset mid-run, then a full run with a bounded wait for done
    drive(1,1,0,4'b0000);
    drive(1,0,1,4'b1000);
    chk("mid sig pre-reset", signature, 4'b1000);
    drive(0,0,0,4'b0000);
    chk("mid sig after reset",  signature,   4'b0000);
    chk("mid done after reset", {3'b0,done}, 4'b0000);
    drive(1,0,1,4'b1000);
    chk("mid idle ignores cap", signature, 4'b0000);
    drive(1,1,0,4'b0000);
    drive(1,0,1,4'b1000);
    drive(1,0,1,4'b1000);
    chk("mid final sig", signature, 4'b1011);
    begin
      int waited = 0;
      while (!done && waited < 10) begin
        drive(1,0,0,4'b0000);
        waited++;
      end
      chk("mid done within bound", {3'b0,done}, 4'b0001);
      chk("mid done latency",      4'(waited),  4'd2);
      chk("mid pass",              {3'b0,pass}, 4'b0001);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
